// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package subtractor_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage : subtractor_pkg

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
interface serial_subtractor_if
  import subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             ovf;

  // Producer/consumer side of the subtractor.
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow, ovf
  );

  // The subtractor itself.
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow, ovf
  );

endinterface : serial_subtractor_if

// File: rtl/serial_subtractor_fs.sv
// One-bit full subtractor: x - y - bin.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial a - b: one bit per clock LSB first, result held until taken.
module serial_subtractor
  import subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e state_q, state_d;

  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bin_q, bin_d;
  logic             ovf_q, ovf_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;

  logic accept_c;
  logic shift_c;
  logic last_c;
  logic fs_d;
  logic fs_bout;

  assign accept_c = (state_q == IDLE) & in_valid;
  assign shift_c  = (state_q == SHIFT);
  assign last_c   = shift_c & (cnt_q == CNT_LAST);

  full_subtractor u_fs (
    .x    (a_q[0]),
    .y    (b_q[0]),
    .bin  (bin_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept_c)  state_d = SHIFT;
      SHIFT:   if (last_c)    state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags decoded from the upcoming state so they register in step with it
  always_comb begin
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    unique case (state_d)
      IDLE:    in_ready_d  = 1'b1;
      DONE:    out_valid_d = 1'b1;
      default: ;
    endcase
  end

  // Datapath next-state: load on accept, one bit per SHIFT edge
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    ovf_d   = ovf_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    if (accept_c) begin
      a_d     = a;
      b_d     = b;
      cnt_d   = '0;
      bin_d   = 1'b0;
      ovf_d   = 1'b0;
      a_msb_d = a[WIDTH-1];
      b_msb_d = b[WIDTH-1];
    end else if (shift_c) begin
      a_d    = {1'b0, a_q[WIDTH-1:1]};
      b_d    = {1'b0, b_q[WIDTH-1:1]};
      diff_d = {fs_d, diff_q[WIDTH-1:1]};
      bin_d  = fs_bout;
      cnt_d  = cnt_q + CNT_W'(1);
      // fs_d is the result MSB on the final bit
      if (last_c) begin
        ovf_d = (a_msb_q ^ b_msb_q) & (fs_d ^ a_msb_q);
      end
    end
  end

  // Datapath and handshake registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      diff_q      <= '0;
      cnt_q       <= '0;
      bin_q       <= 1'b0;
      ovf_q       <= 1'b0;
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
    end else begin
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      diff_q      <= diff_d;
      cnt_q       <= cnt_d;
      bin_q       <= bin_d;
      ovf_q       <= ovf_d;
      a_msb_q     <= a_msb_d;
      b_msb_q     <= b_msb_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign borrow    = bin_q;
  assign ovf       = ovf_q;

endmodule : serial_subtractor
